// File: rtl/valu_fold.sv
// valu_fold: folded vector ALU. A warp instruction of SOFT_THREAD lanes is
// captured once, then executed HARD_THREAD lanes per cycle over NBEAT beats.
// The result goes either to register writeback (out_valid_o/out_ready_i) or
// to the SIMT stack as a not-taken mask (out2simt_valid_o/out2simt_ready_i).
// Handshakes: a transfer happens on a clk edge where valid and ready are both
// high; valid and its payload hold steady until that edge.
// Optional feature macro: VALU_FOLD_SKIP_EN skips lane groups whose mask bits
// are all zero (never for VMERGE or SIMT-stack ops).
// dbg_state_o exposes the FSM state (0 IDLE, 1 EXEC, 2 DONE).

`ifndef NUM_THREAD
`define NUM_THREAD 8
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif
`ifndef REGIDX_WIDTH
`define REGIDX_WIDTH 5
`endif
`ifndef REGEXT_WIDTH
`define REGEXT_WIDTH 3
`endif
`ifndef FN_ADD
`define FN_ADD      6'd0
`define FN_SL       6'd1
`define FN_SEQ      6'd2
`define FN_SNE      6'd3
`define FN_XOR      6'd4
`define FN_SR       6'd5
`define FN_OR       6'd6
`define FN_AND      6'd7
`define FN_SUB      6'd10
`define FN_SRA      6'd11
`define FN_SLT      6'd12
`define FN_SGE      6'd13
`define FN_SLTU     6'd14
`define FN_SGEU     6'd15
`define FN_MAX      6'd16
`define FN_MIN      6'd17
`define FN_MAXU     6'd18
`define FN_MINU     6'd19
`define FN_VMANDNOT 6'd24
`define FN_VMORNOT  6'd25
`define FN_VMNAND   6'd26
`define FN_VMNOR    6'd27
`define FN_VMXNOR   6'd28
`define FN_VID      6'd32
`define FN_VMERGE   6'd33
`endif

module valu_fold #(
    parameter int SOFT_THREAD = `NUM_THREAD,
    parameter int HARD_THREAD = `NUM_THREAD/4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid_i,
    output logic                                      in_ready_o,
    input  logic [SOFT_THREAD*`XLEN-1:0]              in1_i,
    input  logic [SOFT_THREAD*`XLEN-1:0]              in2_i,
    input  logic [SOFT_THREAD-1:0]                    mask_i,
    input  logic [5:0]                                ctrl_alu_fn_i,
    input  logic                                      ctrl_reverse_i,
    input  logic                                      ctrl_simt_stack_i,
    input  logic [`DEPTH_WARP-1:0]                    ctrl_wid_i,
    input  logic [`REGIDX_WIDTH+`REGEXT_WIDTH-1:0]    ctrl_reg_idxw_i,
    input  logic                                      ctrl_wvd_i,
    output logic                                      out_valid_o,
    input  logic                                      out_ready_i,
    output logic [SOFT_THREAD*`XLEN-1:0]              wb_wvd_rd_o,
    output logic [SOFT_THREAD-1:0]                    wvd_mask_o,
    output logic                                      wvd_o,
    output logic [`REGIDX_WIDTH+`REGEXT_WIDTH-1:0]    reg_idxw_o,
    output logic [`DEPTH_WARP-1:0]                    warp_id_o,
    output logic                                      out2simt_valid_o,
    input  logic                                      out2simt_ready_i,
    output logic [SOFT_THREAD-1:0]                    if_mask_o,
    output logic [`DEPTH_WARP-1:0]                    wid_o,
    output logic [1:0]                                dbg_state_o
);

    localparam int XL    = `XLEN;
    localparam int NBEAT = SOFT_THREAD / HARD_THREAD;
    localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int SHW   = $clog2(XL);
    localparam int IDXW  = `REGIDX_WIDTH + `REGEXT_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (SOFT_THREAD % HARD_THREAD != 0) begin : g_bad_cfg
            $error("valu_fold: SOFT_THREAD must be a multiple of HARD_THREAD");
        end
    endgenerate

    logic [1:0]                state_q, state_d;
    logic [BW-1:0]             beat_q, beat_d;
    logic [SOFT_THREAD*XL-1:0] in1_q, in1_d, in2_q, in2_d;
    logic [SOFT_THREAD-1:0]    mask_q, mask_d;
    logic [5:0]                fn_q, fn_d;
    logic                      rev_q, rev_d, simt_q, simt_d, wvd_q, wvd_d;
    logic [`DEPTH_WARP-1:0]    wid_q, wid_d;
    logic [IDXW-1:0]           idx_q, idx_d;
    logic [SOFT_THREAD*XL-1:0] res_q, res_d;
    logic [SOFT_THREAD-1:0]    wm_q, wm_d, ifm_q, ifm_d;

    // One ALU lane: returns {cmp, result}; compares return the flag as data.
    function automatic logic [XL:0] lane_alu(input logic [5:0] fn,
                                             input logic [XL-1:0] a,
                                             input logic [XL-1:0] b,
                                             input logic m,
                                             input logic [XL-1:0] sidx);
        logic [XL-1:0] r;
        logic          c;
        r = '0;
        c = 1'b0;
        case (fn)
            `FN_ADD:      r = a + b;
            `FN_SUB:      r = a - b;
            `FN_SL:       r = a << b[SHW-1:0];
            `FN_SR:       r = a >> b[SHW-1:0];
            `FN_SRA:      r = $unsigned($signed(a) >>> b[SHW-1:0]);
            `FN_AND:      r = a & b;
            `FN_OR:       r = a | b;
            `FN_XOR:      r = a ^ b;
            `FN_SLT:      c = $signed(a) < $signed(b);
            `FN_SLTU:     c = a < b;
            `FN_SEQ:      c = a == b;
            `FN_SNE:      c = a != b;
            `FN_SGE:      c = $signed(a) >= $signed(b);
            `FN_SGEU:     c = a >= b;
            `FN_MAX:      r = ($signed(a) > $signed(b)) ? a : b;
            `FN_MIN:      r = ($signed(a) < $signed(b)) ? a : b;
            `FN_MAXU:     r = (a > b) ? a : b;
            `FN_MINU:     r = (a < b) ? a : b;
            `FN_VMANDNOT: r = ~a & b;
            `FN_VMORNOT:  r = ~a | b;
            `FN_VMNAND:   r = ~(a & b);
            `FN_VMNOR:    r = ~(a | b);
            `FN_VMXNOR:   r = ~(a ^ b);
            `FN_VID:      r = sidx;
            `FN_VMERGE:   r = m ? a : b;
            default:      r = '0;
        endcase
        r = r | XL'(c);
        return {c, r};
    endfunction

    // Next-state: issue capture, one lane group per EXEC cycle, DONE handshake.
    always_comb begin : p_next
        int               s;
        logic [XL-1:0]    op_a;
        logic [XL-1:0]    op_b;
        logic [XL:0]      alu;
        logic             skip_ok;
        logic             skip_in;
        logic             found_nxt;
        logic             last;
        logic [BW-1:0]    nxt_beat;
        logic [BW-1:0]    first_beat;
        logic [NBEAT-1:0] grp_nz_q;
        logic [NBEAT-1:0] grp_nz_i;

        state_d = state_q;  beat_d = beat_q;
        in1_d   = in1_q;    in2_d  = in2_q;   mask_d = mask_q;
        fn_d    = fn_q;     rev_d  = rev_q;   simt_d = simt_q;
        wvd_d   = wvd_q;    wid_d  = wid_q;   idx_d  = idx_q;
        res_d   = res_q;    wm_d   = wm_q;    ifm_d  = ifm_q;
        s = 0; op_a = '0; op_b = '0; alu = '0; last = 1'b0;

`ifdef VALU_FOLD_SKIP_EN
        skip_ok = (fn_q != `FN_VMERGE) && !simt_q;
        skip_in = (ctrl_alu_fn_i != `FN_VMERGE) && !ctrl_simt_stack_i;
`else
        skip_ok = 1'b0;
        skip_in = 1'b0;
`endif

        // Group occupancy and the first/next non-empty group.
        for (int g = 0; g < NBEAT; g++) begin
            grp_nz_q[g] = |mask_q[g*HARD_THREAD +: HARD_THREAD];
            grp_nz_i[g] = |mask_i[g*HARD_THREAD +: HARD_THREAD];
        end
        first_beat = '0;
        found_nxt  = 1'b0;
        nxt_beat   = '0;
        for (int g = NBEAT - 1; g >= 0; g--) begin
            if (grp_nz_i[g]) first_beat = BW'(g);
            if (g > int'(beat_q) && grp_nz_q[g]) begin
                found_nxt = 1'b1;
                nxt_beat  = BW'(g);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    in1_d   = in1_i;            in2_d  = in2_i;
                    mask_d  = mask_i;           fn_d   = ctrl_alu_fn_i;
                    rev_d   = ctrl_reverse_i;   simt_d = ctrl_simt_stack_i;
                    wvd_d   = ctrl_wvd_i;       wid_d  = ctrl_wid_i;
                    idx_d   = ctrl_reg_idxw_i;
                    res_d   = '0;  wm_d = '0;  ifm_d = '0;
                    beat_d  = skip_in ? first_beat : '0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                for (int j = 0; j < HARD_THREAD; j++) begin
                    s    = int'(beat_q) * HARD_THREAD + j;
                    op_a = rev_q ? in2_q[s*XL +: XL] : in1_q[s*XL +: XL];
                    op_b = rev_q ? in1_q[s*XL +: XL] : in2_q[s*XL +: XL];
                    alu  = lane_alu(fn_q, op_a, op_b, mask_q[s], XL'(s));
                    if (skip_ok && !grp_nz_q[beat_q]) begin
                        // Only reachable for an all-zero mask: the single EXEC beat.
                        res_d[s*XL +: XL] = '0;
                        wm_d[s]           = 1'b0;
                        ifm_d[s]          = 1'b0;
                    end else begin
                        res_d[s*XL +: XL] = alu[XL-1:0];
                        wm_d[s]           = (fn_q == `FN_VMERGE) ? 1'b1 : mask_q[s];
                        ifm_d[s]          = ~alu[XL];
                    end
                end
                last = skip_ok ? !found_nxt : (beat_q == BW'(NBEAT - 1));
                if (last) begin
                    state_d = S_DONE;
                    beat_d  = '0;
                end else begin
                    beat_d  = skip_ok ? nxt_beat : beat_q + BW'(1);
                end
            end
            S_DONE: begin
                if (simt_q) begin
                    if (out2simt_ready_i) state_d = S_IDLE;
                end else if (wvd_q) begin
                    if (out_ready_i) state_d = S_IDLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;  beat_q <= '0;
            in1_q   <= '0;      in2_q  <= '0;  mask_q <= '0;
            fn_q    <= '0;      rev_q  <= 1'b0; simt_q <= 1'b0;
            wvd_q   <= 1'b0;    wid_q  <= '0;  idx_q  <= '0;
            res_q   <= '0;      wm_q   <= '0;  ifm_q  <= '0;
        end else begin
            state_q <= state_d; beat_q <= beat_d;
            in1_q   <= in1_d;   in2_q  <= in2_d; mask_q <= mask_d;
            fn_q    <= fn_d;    rev_q  <= rev_d; simt_q <= simt_d;
            wvd_q   <= wvd_d;   wid_q  <= wid_d; idx_q  <= idx_d;
            res_q   <= res_d;   wm_q   <= wm_d;  ifm_q  <= ifm_d;
        end
    end

    assign in_ready_o       = (state_q == S_IDLE);
    assign out_valid_o      = (state_q == S_DONE) && wvd_q && !simt_q;
    assign out2simt_valid_o = (state_q == S_DONE) && simt_q;
    assign wb_wvd_rd_o      = res_q;
    assign wvd_mask_o       = wm_q;
    assign wvd_o            = wvd_q;
    assign reg_idxw_o       = idx_q;
    assign warp_id_o        = wid_q;
    assign if_mask_o        = ifm_q;
    assign wid_o            = wid_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_valu_fold.sv
// tb_valu_fold: randomized and directed checks of valu_fold (SOFT=8, HARD=2)
// against a lane-by-lane arithmetic reference model.
`timescale 1ns/1ps

`ifndef XLEN
`define XLEN 32
`endif
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif
`ifndef REGIDX_WIDTH
`define REGIDX_WIDTH 5
`endif
`ifndef REGEXT_WIDTH
`define REGEXT_WIDTH 3
`endif
`ifndef FN_ADD
`define FN_ADD      6'd0
`define FN_SL       6'd1
`define FN_SEQ      6'd2
`define FN_SNE      6'd3
`define FN_XOR      6'd4
`define FN_SR       6'd5
`define FN_OR       6'd6
`define FN_AND      6'd7
`define FN_SUB      6'd10
`define FN_SRA      6'd11
`define FN_SLT      6'd12
`define FN_SGE      6'd13
`define FN_SLTU     6'd14
`define FN_SGEU     6'd15
`define FN_MAX      6'd16
`define FN_MIN      6'd17
`define FN_MAXU     6'd18
`define FN_MINU     6'd19
`define FN_VMANDNOT 6'd24
`define FN_VMORNOT  6'd25
`define FN_VMNAND   6'd26
`define FN_VMNOR    6'd27
`define FN_VMXNOR   6'd28
`define FN_VID      6'd32
`define FN_VMERGE   6'd33
`endif

module tb_valu_fold;
  localparam int SOFT = 8;
  localparam int HARD = 2;
  localparam int XL   = `XLEN;
  localparam int NB   = SOFT / HARD;
  localparam int W    = SOFT * XL;
  localparam int IDXW = `REGIDX_WIDTH + `REGEXT_WIDTH;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [W-1:0]           in1 = '0;
  logic [W-1:0]           in2 = '0;
  logic [SOFT-1:0]        mask = '0;
  logic [5:0]             fn = '0;
  logic                   rev = 1'b0, simt = 1'b0, wvd = 1'b0;
  logic [`DEPTH_WARP-1:0] wid = '0;
  logic [IDXW-1:0]        idx = '0;
  logic                   out_valid, out_ready = 1'b0;
  logic [W-1:0]           wb_data;
  logic [SOFT-1:0]        wb_mask, if_mask;
  logic                   wvd_out;
  logic [IDXW-1:0]        idx_out;
  logic [`DEPTH_WARP-1:0] warp_id_out, wid_out;
  logic                   simt_valid, simt_ready = 1'b0;
  logic [1:0]             dbg_state;

  valu_fold #(.SOFT_THREAD(SOFT), .HARD_THREAD(HARD)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in1_i(in1), .in2_i(in2), .mask_i(mask),
    .ctrl_alu_fn_i(fn), .ctrl_reverse_i(rev), .ctrl_simt_stack_i(simt),
    .ctrl_wid_i(wid), .ctrl_reg_idxw_i(idx), .ctrl_wvd_i(wvd),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .wb_wvd_rd_o(wb_data), .wvd_mask_o(wb_mask),
    .wvd_o(wvd_out), .reg_idxw_o(idx_out), .warp_id_o(warp_id_out),
    .out2simt_valid_o(simt_valid), .out2simt_ready_i(simt_ready),
    .if_mask_o(if_mask), .wid_o(wid_out), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0]    exp_q[$];
  logic [SOFT-1:0] exp_m_q[$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Reference for one logical lane: plain integer arithmetic on the operands.
  function automatic logic [XL-1:0] ref_lane(input logic [5:0] f, input logic [XL-1:0] x,
                                             input logic [XL-1:0] y, input logic m,
                                             input int s, output logic cmp);
    int          sx, sy;
    int unsigned ux, uy, sh;
    logic [XL-1:0] r;
    sx = int'(x); sy = int'(y); ux = x; uy = y; sh = uy % XL;
    cmp = 1'b0; r = '0;
    case (f)
      `FN_ADD:      r = ux + uy;
      `FN_SUB:      r = ux - uy;
      `FN_SL:       r = ux << sh;
      `FN_SR:       r = ux >> sh;
      `FN_SRA:      r = sx >>> sh;
      `FN_AND:      r = x & y;
      `FN_OR:       r = x | y;
      `FN_XOR:      r = x ^ y;
      `FN_SLT:      cmp = (sx < sy);
      `FN_SLTU:     cmp = (ux < uy);
      `FN_SEQ:      cmp = (ux == uy);
      `FN_SNE:      cmp = (ux != uy);
      `FN_SGE:      cmp = (sx >= sy);
      `FN_SGEU:     cmp = (ux >= uy);
      `FN_MAX:      r = (sx > sy) ? x : y;
      `FN_MIN:      r = (sx < sy) ? x : y;
      `FN_MAXU:     r = (ux > uy) ? x : y;
      `FN_MINU:     r = (ux < uy) ? x : y;
      `FN_VMANDNOT: r = (~x) & y;
      `FN_VMORNOT:  r = (~x) | y;
      `FN_VMNAND:   r = ~(x & y);
      `FN_VMNOR:    r = ~(x | y);
      `FN_VMXNOR:   r = ~(x ^ y);
      `FN_VID:      r = XL'(s);
      `FN_VMERGE:   r = m ? x : y;
      default:      r = '0;
    endcase
    if (cmp) r = 1;
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input logic [5:0] t_fn, input logic [W-1:0] t_in1, input logic [W-1:0] t_in2,
                        input logic [SOFT-1:0] t_mask, input logic t_rev, input logic t_simt,
                        input logic t_wvd, input int stall);
    logic [W-1:0]    e_data;
    logic [SOFT-1:0] e_m, e_if, e_sel;
    logic [XL-1:0]   x, y, r;
    logic            c, elig, grp_on;
    logic [`DEPTH_WARP-1:0] t_wid;
    logic [IDXW-1:0] t_idx;
    int e_lat, kind, lat, n, ngrp;

    t_wid = `DEPTH_WARP'($urandom);
    t_idx = IDXW'($urandom);
    elig  = 1'b0;
`ifdef VALU_FOLD_SKIP_EN
    elig = (t_fn != `FN_VMERGE) && !t_simt;
`endif
    ngrp = 0;
    for (int g = 0; g < NB; g++) if (|t_mask[g*HARD +: HARD]) ngrp++;
    e_lat = elig ? ((ngrp == 0) ? 1 : ngrp) : NB;
    e_data = '0; e_m = '0; e_if = '0;
    for (int s = 0; s < SOFT; s++) begin
      x = t_rev ? t_in2[s*XL +: XL] : t_in1[s*XL +: XL];
      y = t_rev ? t_in1[s*XL +: XL] : t_in2[s*XL +: XL];
      r = ref_lane(t_fn, x, y, t_mask[s], s, c);
      grp_on = |t_mask[(s/HARD)*HARD +: HARD];
      if (elig && !grp_on) begin
        r = '0; e_m[s] = 1'b0;
      end else begin
        e_m[s]  = (t_fn == `FN_VMERGE) ? 1'b1 : t_mask[s];
        e_if[s] = ~c;
      end
      e_data[s*XL +: XL] = r;
    end
    kind = t_simt ? 2 : (t_wvd ? 1 : 0);
    exp_q.push_back(e_data);
    exp_m_q.push_back((kind == 2) ? e_if : e_m);

    n = 0;
    while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
    check("issue_ready", W'(in_ready), W'(1));
    in1 = t_in1; in2 = t_in2; mask = t_mask; fn = t_fn; rev = t_rev;
    simt = t_simt; wvd = t_wvd; wid = t_wid; idx = t_idx; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in1 = W'({$urandom, $urandom}); mask = SOFT'($urandom);

    lat = 0;
    while (!(out_valid || simt_valid || in_ready) && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    e_data = exp_q.pop_front();
    e_sel  = exp_m_q.pop_front();
    if (kind == 0) begin
      check("none_lat", W'(lat), W'(e_lat + 1));
      check("none_wb_valid", W'(out_valid), W'(0));
      check("none_simt_valid", W'(simt_valid), W'(0));
    end else begin
      check("latency", W'(lat), W'(e_lat));
      check("wb_valid", W'(out_valid), W'(kind == 1));
      check("simt_valid", W'(simt_valid), W'(kind == 2));
      if (kind == 1) begin
        check("wb_data", wb_data, e_data);
        check("wb_mask", W'(wb_mask), W'(e_sel));
        check("wb_ctrl", W'({wvd_out, idx_out, warp_id_out}), W'({1'b1, t_idx, t_wid}));
      end else begin
        check("if_mask", W'(if_mask), W'(e_sel));
        check("simt_wid", W'(wid_out), W'(t_wid));
      end
      // Hold off the matching ready; the other ready must have no effect.
      for (int k = 0; k < stall; k++) begin
        out_ready  = (kind == 2);
        simt_ready = (kind == 1);
        @(posedge clk); #1;
        check("stall_ready", W'(in_ready), W'(0));
        if (kind == 1) begin
          check("stall_valid", W'(out_valid), W'(1));
          check("stall_data", wb_data, e_data);
          check("stall_mask", W'(wb_mask), W'(e_sel));
        end else begin
          check("stall_valid", W'(simt_valid), W'(1));
          check("stall_if", W'(if_mask), W'(e_sel));
        end
      end
      out_ready = (kind == 1); simt_ready = (kind == 2);
      @(posedge clk); #1;
      out_ready = 1'b0; simt_ready = 1'b0;
      check("release_ready", W'(in_ready), W'(1));
      check("release_valids", W'({out_valid, simt_valid}), W'(0));
    end
  endtask

  function automatic logic [W-1:0] lane_index_vec();
    logic [W-1:0] v;
    for (int s = 0; s < SOFT; s++) v[s*XL +: XL] = XL'(s);
    return v;
  endfunction

  function automatic logic [W-1:0] splat(input logic [XL-1:0] val);
    logic [W-1:0] v;
    for (int s = 0; s < SOFT; s++) v[s*XL +: XL] = val;
    return v;
  endfunction

  logic [5:0] fn_tab [25] = '{`FN_ADD, `FN_SL, `FN_SEQ, `FN_SNE, `FN_XOR, `FN_SR, `FN_OR,
                              `FN_AND, `FN_SUB, `FN_SRA, `FN_SLT, `FN_SGE, `FN_SLTU, `FN_SGEU,
                              `FN_MAX, `FN_MIN, `FN_MAXU, `FN_MINU, `FN_VMANDNOT, `FN_VMORNOT,
                              `FN_VMNAND, `FN_VMNOR, `FN_VMXNOR, `FN_VID, `FN_VMERGE};

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0]    r1, r2;
    logic [SOFT-1:0] rm;
    int pulses;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", W'(in_ready), W'(1));
    check("rst_valids", W'({out_valid, simt_valid}), W'(0));
    check("rst_data", wb_data, '0);
    check("rst_masks", W'({wb_mask, if_mask}), W'(0));
    check("rst_ctrl", W'({wvd_out, idx_out, warp_id_out, wid_out}), W'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", W'(in_ready), W'(1));

    // Directed cases.
    run_op(`FN_ADD, lane_index_vec(), splat(100), 8'hFF, 1'b0, 1'b0, 1'b1, 0);
    run_op(`FN_VID, '0, '0, 8'hFF, 1'b0, 1'b0, 1'b1, 0);
    run_op(`FN_SLT, lane_index_vec(), splat(4), 8'hFF, 1'b0, 1'b1, 1'b1, 0);
    run_op(`FN_ADD, lane_index_vec(), splat(7), 8'hFF, 1'b0, 1'b0, 1'b1, 5);
    run_op(`FN_ADD, lane_index_vec(), splat(100), 8'h03, 1'b0, 1'b0, 1'b1, 0);
    run_op(`FN_SUB, lane_index_vec(), splat(3), 8'h00, 1'b0, 1'b0, 1'b1, 0);
    run_op(`FN_VMERGE, lane_index_vec(), splat(55), 8'h5A, 1'b0, 1'b0, 1'b1, 1);
    run_op(`FN_VMANDNOT, splat(32'hF0F0_1234), splat(32'hFF00_FFFF), 8'hFF, 1'b1, 1'b0, 1'b1, 0);

    // Reset while the third beat is in flight: instruction is dropped.
    in1 = lane_index_vec(); in2 = splat(9); mask = 8'hFF; fn = `FN_ADD;
    simt = 1'b0; wvd = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_ready", W'(in_ready), W'(1));
    check("midrst_data", wb_data, '0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid || simt_valid) pulses++;
      @(posedge clk); #1;
    end
    check("midrst_pulses", W'(pulses), W'(0));
    run_op(`FN_XOR, lane_index_vec(), splat(32'hA5), 8'hFF, 1'b0, 1'b0, 1'b1, 0);

    // Randomized instructions.
    for (int t = 0; t < 60; t++) begin
      for (int s = 0; s < SOFT; s++) begin
        r1[s*XL +: XL] = ($urandom_range(0, 1) != 0) ? XL'($urandom) : XL'($urandom_range(0, 7));
        r2[s*XL +: XL] = ($urandom_range(0, 1) != 0) ? XL'($urandom) : XL'($urandom_range(0, 7));
      end
      case ($urandom_range(0, 5))
        0:       rm = 8'h00;
        1:       rm = 8'hFF;
        2:       rm = 8'h03;
        default: rm = SOFT'($urandom);
      endcase
      run_op(fn_tab[$urandom_range(0, 24)], r1, r2, rm, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/valu_fold.md
VALU_FOLD -- requirements
Module: valu_fold

Interface
REQ-001 SOFT_THREAD, default `NUM_THREAD, number of logical lanes per warp instruction.
REQ-002 HARD_THREAD, default `NUM_THREAD/4, number of physical ALU lanes; SOFT_THREAD%HARD_THREAD!=0 SHALL stop elaboration with an error.
REQ-003 clk  in  1  the single clock.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 in_valid_i  in  1  the issue request is valid.
REQ-006 in_ready_o  out  1  the block can accept an issue.
REQ-007 in1_i, in2_i  in  SOFT_THREAD*`XLEN each  operands, one input per line of declaration, lane s at bits [(s+1)*`XLEN-1 -: `XLEN].
REQ-008 mask_i  in  SOFT_THREAD  active-lane mask.
REQ-009 ctrl_alu_fn_i  in  6  ALU function code (`FN_*).
REQ-010 ctrl_reverse_i  in  1  swaps the operands.
REQ-011 ctrl_simt_stack_i  in  1  result is a branch mask for the SIMT stack.
REQ-012 ctrl_wid_i  in  `DEPTH_WARP  warp id.
REQ-013 ctrl_reg_idxw_i  in  `REGIDX_WIDTH+`REGEXT_WIDTH  destination register.
REQ-014 ctrl_wvd_i  in  1  writes the vector destination.
REQ-015 out_valid_o / out_ready_i  out/in  1  writeback handshake.
REQ-016 wb_wvd_rd_o  out  SOFT_THREAD*`XLEN  writeback data.
REQ-017 wvd_mask_o  out  SOFT_THREAD  writeback lane mask.
REQ-018 wvd_o, reg_idxw_o, warp_id_o  out  1/idx/`DEPTH_WARP  registered copies of the captured control fields.
REQ-019 out2simt_valid_o / out2simt_ready_i  out/in  1  SIMT handshake.
REQ-020 if_mask_o, wid_o  out  SOFT_THREAD/`DEPTH_WARP  the not-taken mask and the warp id.

Function
REQ-021 The block SHALL use three states: IDLE, EXEC and DONE.
REQ-022 Derived count: NBEAT=SOFT_THREAD/HARD_THREAD.
REQ-023 in_ready_o SHALL be 1 only in IDLE.
REQ-024 On in_valid_i&in_ready_o the block SHALL capture all inputs into registers, set beat=0 and go to EXEC.
REQ-025 Each EXEC cycle SHALL process the lane group beat (soft lanes beat*HARD_THREAD+j) through HARD_THREAD ALUs and register the results; beat SHALL then increment.
REQ-026 After the last group the block SHALL go to DONE, so output valid appears NBEAT cycles after the accept edge.
REQ-027 Per-lane semantics:
- ctrl_reverse_i: the operands are swapped.
- VMANDNOT/VMORNOT: in1 is inverted into AND/OR.
- VMNAND/VMNOR: the AND/OR result is inverted.
- VMXNOR: the XOR result is inverted.
- VID: the lane value is the global soft-lane index s, not j.
- VMERGE: the lane value is mask?in1:in2 and wvd_mask is all-ones.
- All other codes: the ALU result is written with the lane's mask bit.
REQ-028 if_mask bit s SHALL be ~cmp of lane s.
REQ-029 In DONE with ctrl_simt_stack SHALL assert out2simt_valid_o only.
REQ-030 In DONE with ctrl_wvd&!ctrl_simt_stack SHALL assert out_valid_o only.
REQ-031 The block SHALL return to IDLE on the corresponding ready.
REQ-032 If neither valid is asserted in DONE, the block SHALL return to IDLE in the next cycle with no output.
REQ-033 Outputs SHALL stay stable while valid and not ready.
REQ-034 NBEAT=1 SHALL give a one-cycle EXEC with identical semantics.

Reset
REQ-035 With rst=1 at a clk edge, the state SHALL be IDLE, beat=0, and out_valid_o=out2simt_valid_o=0.
REQ-036 With rst=1 at a clk edge, the data outputs SHALL be 0.
REQ-037 Reset during EXEC/DONE SHALL discard the instruction with no output pulse.
REQ-038 in_ready_o SHALL be 1 in the first cycle after reset.

Configuration
REQ-039 With VALU_FOLD_SKIP_EN defined, EXEC SHALL skip lane groups whose mask bits are all zero; skipped lanes write data 0 and mask 0.
REQ-040 With VALU_FOLD_SKIP_EN defined, an all-zero mask SHALL take exactly one EXEC cycle.
REQ-041 Skipping SHALL never apply to VMERGE or ctrl_simt_stack ops.
REQ-042 Without VALU_FOLD_SKIP_EN, EXEC SHALL always take NBEAT cycles.

Verification
REQ-043 SOFT=8, HARD=2, FN_ADD, in1 lane s=s, in2=100, mask=FF, wvd=1 -> out_valid 4 cycles after accept; lane s=100+s; wvd_mask=FF.
REQ-044 SOFT=8, HARD=2, FN_VID, mask=FF -> lanes 0..7 equal 0..7 (not 0,1,0,1...).
REQ-045 SOFT=8, HARD=2, simt_stack=1, FN_SLT, in1=lane index, in2=4 -> out2simt_valid, if_mask=F0, out_valid stays 0.
REQ-046 out_ready_i held low for 5 cycles in DONE -> data stable, in_ready_o=0; one-cycle ready -> IDLE, in_ready_o=1 next cycle.
REQ-047 rst pulse in EXEC beat 2 -> no valid pulse; the next issue executes normally.
REQ-048 SKIP_EN, SOFT=8, HARD=2, mask=0x03 -> out_valid 1 cycle after accept; lanes 2..7 data 0; mask 03.
